pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset; it is word-aligned (bits [1:0] = 00).
REQ-002 SHALL use one clock and a synchronous, active-high reset. The clock port is clk and the reset port is reset. This is fixed.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: advance on this edge when 1, hold all state when 0.
REQ-006 SHALL have port branch_offset_sl2, input, 32 bits: sign-extended branch offset, already shifted left by 2 (from the shift_left_2 stage).
REQ-007 SHALL have port branch_taken, input, 1 bit: take the branch target.
REQ-008 SHALL have port jump, input, 1 bit: take the J-type target.
REQ-009 SHALL have port jump_index, input, 26 bits: J-type instr_index field.
REQ-010 SHALL have port jump_reg, input, 1 bit: take the register target (jr).
REQ-011 SHALL have port rs_value, input, 32 bits: register target for jr.
REQ-012 SHALL have port halt, input, 1 bit: stop fetching.
REQ-013 SHALL have port pc, output, 32 bits: current program counter (registered).
REQ-014 SHALL have port pc_plus4, output, 32 bits: pc + 4 (combinational).
REQ-015 SHALL have port running, output, 1 bit: 1 only in state RUN.
REQ-016 SHALL have port misaligned, output, 1 bit: sticky flag for a misaligned target.
REQ-017 SHALL have port instr_count, output, 32 bits: count of retired PC updates.

Function
REQ-018 SHALL compute pc_plus4 = pc + 4 modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
REQ-019 SHALL compute branch_target = pc_plus4 + branch_offset_sl2 modulo 2^32, with no overflow detection.
REQ-020 SHALL compute jump_target = {pc_plus4[31:28], jump_index, 2'b00}.
REQ-021 SHALL select next_pc with priority jump_reg (rs_value) > jump (jump_target) > branch_taken (branch_target) > pc_plus4.
REQ-022 SHALL implement an FSM with three states: RUN, HALTED and FAULT.
REQ-023 SHALL, in RUN on an edge with enable=1 and halt=1: go to HALTED; pc and instr_count hold.
REQ-024 SHALL, in RUN on an edge with enable=1, halt=0 and next_pc[1:0] != 00: go to FAULT; set misaligned=1; pc and instr_count hold.
REQ-025 SHALL, in RUN on an edge with enable=1, halt=0 and an aligned next_pc: load pc <= next_pc and increment instr_count by 1 (modulo 2^32, 0xFFFFFFFF -> 0).
REQ-026 SHALL give halt precedence over the misalignment check when both apply on the same edge.
REQ-027 SHALL, on any edge with enable=0, change no state, pc, instr_count or misaligned.
REQ-028 SHALL treat HALTED and FAULT as terminal until reset; all control inputs are ignored and all outputs hold.
REQ-029 SHALL drive running = 1 only in RUN; it is 0 in HALTED and FAULT.
REQ-030 SHALL keep pc_plus4 tracking pc in every state.

Reset
REQ-031 SHALL, on a rising edge with reset=1: load pc <= RESET_PC, state <= RUN, instr_count <= 0 and misaligned <= 0.
REQ-032 SHALL let reset dominate enable, halt and all control inputs, from any state, including mid-run, HALTED and FAULT.
REQ-033 SHALL read as pc=RESET_PC, pc_plus4=RESET_PC+4, running=1, misaligned=0 and instr_count=0 in the cycle after reset is released.

Verification
REQ-034 SHALL be verified with: reset, then enable=1 and no control for 3 edges -> pc = 0x0, 0x4, 0x8, 0xC; instr_count = 3.
REQ-035 SHALL be verified with: pc=0x100, branch_taken=1, branch_offset_sl2=0xFFFFFFF8 -> pc=0x0FC next edge; branch_taken=1 together with jump=1 -> the jump target wins.
REQ-036 SHALL be verified with: pc=0xF0000010, jump=1, jump_index=0x0000040 -> pc=0xF0000100.
REQ-037 SHALL be verified with: jump_reg=1, rs_value=0x00000202 -> FAULT, misaligned=1, running=0, pc unchanged for 3 further edges; then reset -> pc=RESET_PC, misaligned=0, running=1.
REQ-038 SHALL be verified with: halt=1 and jump=1 on the same edge -> HALTED, pc and instr_count unchanged; enable toggling afterwards causes no change.
REQ-039 SHALL be verified with: pc=0xFFFFFFFC, sequential advance -> pc=0x00000000; and enable=0 for 2 edges mid-run -> pc and instr_count frozen.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit -- program counter with next-PC selection and a run/halt/fault FSM.
//
// Purpose:
//   Holds the fetch PC and picks the next one from four sources. The priority,
//   highest first, is: register target (jr), J-type target, branch target,
//   then pc+4. When the run ends, either by halt or by a misaligned target,
//   the unit stays frozen until reset.
//
// Ports:
//   clk                in   rising-edge clock for all state
//   reset              in   synchronous, active-high reset
//   enable             in   advance on this edge when 1, hold everything when 0
//   branch_offset_sl2  in   [31:0] sign-extended branch offset, already << 2
//   branch_taken       in   select branch target
//   jump               in   select J-type target
//   jump_index         in   [25:0] J-type instr_index
//   jump_reg           in   select register target
//   rs_value           in   [31:0] register target for jr
//   halt               in   stop fetching (terminal HALTED state)
//   pc                 out  [31:0] current PC (registered)
//   pc_plus4           out  [31:0] pc + 4 (combinational)
//   running            out  1 only while in RUN
//   misaligned         out  sticky flag: a misaligned target was seen
//   instr_count        out  [31:0] number of retired PC updates
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] branch_offset_sl2,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] rs_value,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        running,
  output logic        misaligned,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mis_q, mis_d;

  logic [31:0] pc_plus4_w;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc;

  // Adders wrap modulo 2^32 by construction.
  assign pc_plus4_w    = pc_q + 32'd4;
  assign branch_target = pc_plus4_w + branch_offset_sl2;
  assign jump_target   = {pc_plus4_w[31:28], jump_index, 2'b00};

  always_comb begin
    next_pc = pc_plus4_w;
    if (jump_reg) begin
      next_pc = rs_value;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

  // Next-state logic. Only RUN with enable=1 can change anything.
  // Halt is tested before alignment, so a halted run never sets the flag.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    if (enable && (state_q == S_RUN)) begin
      if (halt) begin
        state_d = S_HALTED;
      end else if (next_pc[1:0] != 2'b00) begin
        state_d = S_FAULT;
        mis_d   = 1'b1;
      end else begin
        pc_d  = next_pc;
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;
  assign running     = (state_q == S_RUN);
  assign misaligned  = mis_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- scoreboard testbench for pc_unit.
//
// A stimulus process drives one transaction per cycle on the falling edge.
// It advances a behavioural model and pushes the expected post-edge outputs
// into a queue. A separate monitor pops one entry after every rising edge and
// compares it with the DUT. Directed steps carry extra literal PC and count
// values that come straight from the worked examples.
module tb_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, enable, branch_taken, jump, jump_reg, halt;
  logic [31:0] branch_offset_sl2, rs_value;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus4, instr_count;
  logic        running, misaligned;

  pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .branch_offset_sl2(branch_offset_sl2), .branch_taken(branch_taken),
    .jump(jump), .jump_index(jump_index), .jump_reg(jump_reg),
    .rs_value(rs_value), .halt(halt),
    .pc(pc), .pc_plus4(pc_plus4), .running(running),
    .misaligned(misaligned), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, en, hlt, jr, j, bt;
    logic [31:0] rs, off;
    logic [25:0] idx;
  } stim_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        run;
    logic        mis;
    logic [31:0] cnt;
    bit          lp_en;
    logic [31:0] lp;
    bit          lc_en;
    logic [31:0] lc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_txn  = 0;
  bit   stim_done = 1'b0;

  // Behavioural model: plain architectural state.
  // Mode 0 = running, 1 = halted, 2 = faulted.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  int          m_mode;
  logic        m_mis;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, req);
  endtask

  // Monitor: the DUT presents a new output set after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_txn++;
        $display("txn %0d %s: pc=%h pc4=%h run=%0b mis=%0b cnt=%0d",
                 n_txn, e.name, pc, pc_plus4, running, misaligned, instr_count);
        chk({e.name, ".pc"}, pc, e.pc);
        chk({e.name, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
        chk({e.name, ".running"}, {31'd0, running}, {31'd0, e.run});
        chk({e.name, ".misaligned"}, {31'd0, misaligned}, {31'd0, e.mis});
        chk({e.name, ".instr_count"}, instr_count, e.cnt);
        if (e.lp_en) chk({e.name, ".pc_literal"}, pc, e.lp);
        if (e.lc_en) chk({e.name, ".cnt_literal"}, instr_count, e.lc);
      end
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.en = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s, input string name,
                      input bit lp_en, input logic [31:0] lp,
                      input bit lc_en, input logic [31:0] lc);
    exp_t        e;
    logic [31:0] p4, tgt;
    @(negedge clk);
    reset = s.rst; enable = s.en; halt = s.hlt; jump_reg = s.jr; jump = s.j;
    branch_taken = s.bt; rs_value = s.rs; branch_offset_sl2 = s.off;
    jump_index = s.idx;
    if (s.rst) begin
      m_pc = RST_PC; m_cnt = 0; m_mode = 0; m_mis = 1'b0;
    end else if (s.en && m_mode == 0) begin
      if (s.hlt) begin
        m_mode = 1;
      end else begin
        p4 = m_pc + 32'd4;
        if (s.jr)      tgt = s.rs;
        else if (s.j)  tgt = (p4 & 32'hF000_0000) | ({6'd0, s.idx} * 32'd4);
        else if (s.bt) tgt = p4 + s.off;
        else           tgt = p4;
        if (tgt % 4 != 0) begin
          m_mode = 2; m_mis = 1'b1;
        end else begin
          m_pc = tgt; m_cnt = m_cnt + 32'd1;
        end
      end
    end
    e.name = name; e.pc = m_pc; e.run = (m_mode == 0); e.mis = m_mis;
    e.cnt = m_cnt; e.lp_en = lp_en; e.lp = lp; e.lc_en = lc_en; e.lc = lc;
    sb.push_back(e);
  endtask

  function automatic stim_t rnd();
    stim_t s;
    s.rst = ($urandom_range(0, 39) == 0);
    s.en  = ($urandom_range(0, 3) != 0);
    s.hlt = ($urandom_range(0, 29) == 0);
    s.jr  = ($urandom_range(0, 5) == 0);
    s.j   = ($urandom_range(0, 5) == 0);
    s.bt  = ($urandom_range(0, 3) == 0);
    s.rs  = $urandom();
    if ($urandom_range(0, 7) != 0) s.rs[1:0] = 2'b00;
    s.off = $urandom();
    if ($urandom_range(0, 9) != 0) s.off[1:0] = 2'b00;
    s.idx = 26'($urandom());
    return s;
  endfunction

  initial begin
    stim_t s;
    reset = 1'b1; enable = 1'b0; halt = 1'b0; jump_reg = 1'b0; jump = 1'b0;
    branch_taken = 1'b0; rs_value = '0; branch_offset_sl2 = '0; jump_index = '0;
    m_pc = RST_PC; m_cnt = 0; m_mode = 0; m_mis = 1'b0;

    // Reset, then three plain advances.
    s = idle(); s.rst = 1'b1; s.en = 1'b0;
    step(s, "reset", 1, RST_PC, 1, 0);
    step(idle(), "seq1", 1, 32'h4, 1, 1);
    step(idle(), "seq2", 1, 32'h8, 1, 2);
    step(idle(), "seq3", 1, 32'hC, 1, 3);

    // Branch backwards from 0x100.
    s = idle(); s.jr = 1'b1; s.rs = 32'h100;
    step(s, "jr_0x100", 1, 32'h100, 1, 4);
    s = idle(); s.bt = 1'b1; s.off = 32'hFFFF_FFF8;
    step(s, "branch_back", 1, 32'h0FC, 1, 5);
    // Jump beats branch: branch would give 0x120, jump gives 0x100.
    s = idle(); s.bt = 1'b1; s.off = 32'h20; s.j = 1'b1; s.idx = 26'h40;
    step(s, "jump_over_branch", 1, 32'h100, 1, 6);

    // J-type target keeps the upper nibble of pc+4.
    s = idle(); s.jr = 1'b1; s.rs = 32'hF000_0010;
    step(s, "jr_hi", 1, 32'hF000_0010, 1, 7);
    s = idle(); s.j = 1'b1; s.idx = 26'h000_0040;
    step(s, "jump_region", 1, 32'hF000_0100, 1, 8);

    // Wrap at the top of the address space, then freeze with enable=0.
    s = idle(); s.jr = 1'b1; s.rs = 32'hFFFF_FFFC;
    step(s, "jr_top", 1, 32'hFFFF_FFFC, 1, 9);
    step(idle(), "wrap", 1, 32'h0, 1, 10);
    s = idle(); s.en = 1'b0; s.j = 1'b1; s.idx = 26'h123;
    step(s, "en0_a", 1, 32'h0, 1, 10);
    step(s, "en0_b", 1, 32'h0, 1, 10);

    // Halt wins over jump, then the state is terminal.
    s = idle(); s.hlt = 1'b1; s.j = 1'b1; s.idx = 26'h55;
    step(s, "halt_jump", 1, 32'h0, 1, 10);
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.en = i[0]; s.j = 1'b1; s.idx = 26'h77;
      step(s, "halted_hold", 1, 32'h0, 1, 10);
    end

    // Misaligned register target faults; the fault holds until reset.
    s = idle(); s.rst = 1'b1;
    step(s, "reset2", 1, RST_PC, 1, 0);
    step(idle(), "seq_after_reset", 1, 32'h4, 1, 1);
    s = idle(); s.jr = 1'b1; s.rs = 32'h0000_0202;
    step(s, "jr_misaligned", 1, 32'h4, 1, 1);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.jr = 1'b1; s.rs = 32'h400;
      step(s, "fault_hold", 1, 32'h4, 1, 1);
    end
    s = idle(); s.rst = 1'b1; s.hlt = 1'b1;
    step(s, "reset_from_fault", 1, RST_PC, 1, 0);

    // Halt beats the misalignment check on the same edge.
    s = idle(); s.hlt = 1'b1; s.jr = 1'b1; s.rs = 32'h3;
    step(s, "halt_over_misalign", 1, RST_PC, 1, 0);
    s = idle(); s.rst = 1'b1;
    step(s, "reset3", 1, RST_PC, 1, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) step(rnd(), "rand", 0, '0, 0, '0);

    @(negedge clk);
    @(negedge clk);
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard stop if the stimulus process ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: stimulus not finished at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

endmodule
